// File: rtl/uart_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its UART/compute-core neighbours.
// master = sequencer side, slave = UART receiver/transmitter + core side.
interface uart_frame_sequencer_if #(
  parameter int unsigned DATA_W = 128
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] core_din;
  logic              core_din_valid;
  logic [DATA_W-1:0] core_dout;
  logic              core_dout_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              overrun;
  logic              timeout_err;

  modport master (
    input  rx_data, rx_valid, core_dout, core_dout_valid, tx_ready,
    output core_din, core_din_valid, tx_data, tx_valid, busy, overrun, timeout_err
  );

  modport slave (
    output rx_data, rx_valid, core_dout, core_dout_valid, tx_ready,
    input  core_din, core_din_valid, tx_data, tx_valid, busy, overrun, timeout_err
  );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Collects UART bytes into a frame, launches it into the compute core, waits for the
// result under a timeout and streams it back out. Optional: UART_SEQ_TERM_FLUSH_EN.
module uart_frame_sequencer #(
  parameter int unsigned FRAME_BYTES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_frame_sequencer_if.master bus
);
  localparam int unsigned DATA_W = 8 * FRAME_BYTES;
  localparam int unsigned CNT_W  = $clog2(FRAME_BYTES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FRAME_BYTES);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, SEND} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]  rx_cnt;
  logic [CNT_W-1:0]  tx_left;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] tx_shift;
  logic              overrun_q;
  logic              timeout_q;

  logic rx_take;
  logic rx_flush;
  logic capture;
  logic tmo_fire;
  logic tx_fire;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_take   = 1'b0;
    rx_flush  = 1'b0;
    capture   = 1'b0;
    tmo_fire  = 1'b0;
    tx_fire   = 1'b0;
    unique case (state)
      COLLECT: begin
        if (bus.rx_valid) begin
`ifdef UART_SEQ_TERM_FLUSH_EN
          if (bus.rx_data == 8'h0D) begin
            // CR on an empty frame is simply swallowed
            rx_flush = (rx_cnt != '0);
            if (rx_cnt != '0) state_nxt = LAUNCH;
          end else
`endif
          begin
            rx_take = 1'b1;
            if (rx_cnt == LAST_BYTE) state_nxt = LAUNCH;
          end
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (bus.core_dout_valid) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end else if (tmo_cnt == TMO_LIMIT) begin
          tmo_fire  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          tx_fire = 1'b1;
          if (tx_left == CNT_W'(1)) state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt    <= '0;
      din_q     <= '0;
      tmo_cnt   <= '0;
      tx_shift  <= '0;
      tx_left   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (rx_take) begin
        din_q  <= {din_q[DATA_W-9:0], bus.rx_data};
        rx_cnt <= (rx_cnt == LAST_BYTE) ? '0 : rx_cnt + CNT_W'(1);
      end
`ifdef UART_SEQ_TERM_FLUSH_EN
      // Shifting up by the missing byte count equals receiving that many 8'h00 bytes
      if (rx_flush) begin
        din_q  <= din_q << (8 * (FRAME_BYTES - 32'(rx_cnt)));
        rx_cnt <= '0;
      end
`endif
      if (bus.rx_valid && state != COLLECT) overrun_q <= 1'b1;

      if (state == LAUNCH)    tmo_cnt <= TMO_W'(1);
      else if (state == WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_fire) timeout_q <= 1'b1;

      // A fully drained shift register leaves tx_data at zero between frames
      if (capture) begin
        tx_shift <= bus.core_dout;
        tx_left  <= FULL;
      end else if (tx_fire) begin
        tx_shift <= {tx_shift[DATA_W-9:0], 8'h00};
        tx_left  <= tx_left - CNT_W'(1);
      end
    end
  end

  assign bus.core_din       = din_q;
  assign bus.core_din_valid = (state == LAUNCH);
  assign bus.tx_data        = tx_shift[DATA_W-1 -: 8];
  assign bus.tx_valid       = (state == SEND);
  assign bus.busy           = (state != COLLECT);
  assign bus.overrun        = overrun_q;
  assign bus.timeout_err    = timeout_q;
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench for uart_frame_sequencer: table of frames plus hand-written
// sequences for timeout, overrun, mid-frame reset and CR handling.
module tb_uart_frame_sequencer;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  uart_frame_sequencer_if #(.DATA_W(128)) bus ();

  uart_frame_sequencer #(
    .FRAME_BYTES(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic [127:0] frame;
    int unsigned  delay;
    bit           stall;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] F_A = 128'h3030303030303033_3030303030303034;
  localparam logic [127:0] F_B = 128'h3030303030303039_3030303030303039;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in for the adder core: ASCII digits, high half + low half
  function automatic logic [127:0] adder(input logic [127:0] f);
    logic [63:0] a, b;
    a = f[127:64] - 64'h3030303030303030;
    b = f[63:0]   - 64'h3030303030303030;
    return {64'h0, a + b};
  endfunction

  task automatic send_frame(input logic [127:0] f);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.rx_data  = f[127-8*i -: 8];
      bus.rx_valid = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic collect_tx(input bit stall, input logic [127:0] exp);
    logic [127:0] got;
    logic [7:0]   st_data;
    bit           have_stall;
    bit           rdy;
    int unsigned  n;
    int unsigned  cyc;
    got = '0; st_data = '0; have_stall = 1'b0; rdy = 1'b0; n = 0; cyc = 0;
    while (n < 16 && cyc < 400) begin
      if (have_stall) check("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, st_data});
      have_stall = 1'b0;
      rdy = stall ? !rdy : 1'b1;
      bus.tx_ready = rdy;
      if (bus.tx_valid) begin
        if (rdy) begin
          got = {got[119:0], bus.tx_data};
          n++;
        end else begin
          have_stall = 1'b1;
          st_data    = bus.tx_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.tx_ready = 1'b0;
    check("tx_count", 128'(n), 128'd16);
    check("tx_result", got, exp);
    check("tx_valid_end", 128'(bus.tx_valid), 128'd0);
    check("busy_end", 128'(bus.busy), 128'd0);
  endtask

  task automatic run_vector(input vec_t v, input bit exp_tmo);
    send_frame(v.frame);
    check("launch_valid", 128'(bus.core_din_valid), 128'd1);
    check("launch_din", bus.core_din, v.frame);
    check("launch_busy", 128'(bus.busy), 128'd1);
    @(negedge clk);
    check("launch_pulse", 128'(bus.core_din_valid), 128'd0);
    repeat (v.delay - 1) @(negedge clk);
    bus.core_dout       = adder(v.frame);
    bus.core_dout_valid = 1'b1;
    @(negedge clk);
    bus.core_dout_valid = 1'b0;
    bus.core_dout       = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    check("tx_latency", 128'(bus.tx_valid), 128'd1);
    collect_tx(v.stall, v.exp);
    check("timeout_flag", 128'(bus.timeout_err), 128'(exp_tmo));
  endtask

  initial begin
    vecs[0] = '{F_A, 1, 1'b0, 128'h07};
    vecs[1] = '{F_A, 1, 1'b1, 128'h07};
    vecs[2] = '{F_B, 2, 1'b0, 128'h12};
    vecs[3] = '{128'h3030303030303130_3030303030303035, 64, 1'b0, 128'h105};
    vecs[4] = '{128'h3132333435363738_3031323334353637, 3, 1'b1, 128'h01030507090B0D0F};

    rst = 1'b1;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    bus.core_dout = '0; bus.core_dout_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_core_din", bus.core_din, 128'd0);
    check("rst_flags", {bus.core_din_valid, bus.tx_valid, bus.busy, bus.overrun, bus.timeout_err}, 128'd0);
    check("rst_tx_data", 128'(bus.tx_data), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vector(vecs[i], 1'b0);
    check("no_overrun", 128'(bus.overrun), 128'd0);

    // Core never answers
    send_frame(F_A);
    check("tmo_launch", 128'(bus.core_din_valid), 128'd1);
    repeat (64) @(negedge clk);
    check("tmo_not_yet", {bus.timeout_err, bus.busy}, 128'b01);
    @(negedge clk);
    check("tmo_set", {bus.timeout_err, bus.busy, bus.tx_valid}, 128'b100);
    bus.core_dout       = 128'h55;
    bus.core_dout_valid = 1'b1;
    @(negedge clk);
    bus.core_dout_valid = 1'b0;
    @(negedge clk);
    check("stray_core_valid", {bus.busy, bus.tx_valid}, 128'b00);
    run_vector(vecs[2], 1'b1);

    // Bytes arriving in WAIT and SEND are dropped
    send_frame(F_A);
    @(negedge clk);
    bus.rx_data = 8'hEE; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("overrun_wait", 128'(bus.overrun), 128'd1);
    bus.core_dout = adder(F_A); bus.core_dout_valid = 1'b1;
    @(negedge clk);
    bus.core_dout_valid = 1'b0;
    bus.rx_data = 8'hEE; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("send_stalled", {bus.tx_valid, bus.tx_data}, 128'h100);
    collect_tx(1'b0, 128'h07);
    run_vector(vecs[2], 1'b1);
    check("overrun_sticky", 128'(bus.overrun), 128'd1);

    // Reset in the middle of SEND
    send_frame(F_B);
    @(negedge clk);
    bus.core_dout = 128'hA1A2A3A4_00000000_00000000_00000000; bus.core_dout_valid = 1'b1;
    @(negedge clk);
    bus.core_dout_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_send_data", 128'(bus.tx_data), 128'hA3);
    rst = 1'b1; bus.tx_ready = 1'b0;
    @(negedge clk);
    check("rst2_core_din", bus.core_din, 128'd0);
    check("rst2_flags", {bus.core_din_valid, bus.tx_valid, bus.busy, bus.overrun, bus.timeout_err}, 128'd0);
    check("rst2_tx_data", 128'(bus.tx_data), 128'd0);
    rst = 1'b0;

    // CR handling: leading CR, then 41 42 CR
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h0D; @(negedge clk);
    bus.rx_data = 8'h41; @(negedge clk);
    bus.rx_data = 8'h42; @(negedge clk);
    bus.rx_data = 8'h0D; @(negedge clk);
    bus.rx_valid = 1'b0;
`ifdef UART_SEQ_TERM_FLUSH_EN
    check("flush_launch", 128'(bus.core_din_valid), 128'd1);
    check("flush_din", bus.core_din, 128'h4142_0000_0000_0000_0000_0000_0000_0000);
`else
    check("cr_no_launch", {bus.core_din_valid, bus.busy}, 128'b00);
    check("cr_stored", bus.core_din, 128'h0D41420D);
    @(negedge clk);
    check("cr_still_idle", 128'(bus.busy), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
